// File: rtl/dff_pkg.sv
// Shared defaults for the elastic register pipeline (dff_pipe and its stages).
package dff_pkg;
  localparam int DFF_BW_DATA = 32;
  localparam int DFF_DEPTH   = 4;
  localparam int DFF_RST_VAL = 0;
endpackage

// File: rtl/dff_pipe_stage.sv
// One pipeline stage: a valid flop plus BW_DATA data flops sharing a load enable.
module dff_pipe_stage #(
  parameter int                 BW_DATA = 32,
  parameter logic [BW_DATA-1:0] RST_VAL = '0
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic [BW_DATA-1:0] i_d,
  input  logic               i_valid,
  input  logic               i_ld,
  output logic [BW_DATA-1:0] o_q,
  output logic               o_valid
);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)   o_valid <= 1'b0;
    else if (i_ld) o_valid <= i_valid;
  end

  // Data only moves with a valid word; a bubble leaves the stale value in place.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)               o_q <= RST_VAL;
    else if (i_ld && i_valid)  o_q <= i_d;
  end

endmodule

// File: rtl/dff_pipe.sv
// Elastic valid/ready register pipeline of DEPTH stages with collapsing bubbles.
// Optional synchronous flush port i_sclr when DFF_PIPE_SCLR_EN is defined.
module dff_pipe
  import dff_pkg::*;
#(
  parameter int                 BW_DATA = DFF_BW_DATA,
  parameter int                 DEPTH   = DFF_DEPTH,
  parameter logic [BW_DATA-1:0] RST_VAL = BW_DATA'(DFF_RST_VAL)
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic [BW_DATA-1:0] i_d,
  input  logic               i_valid,
  output logic               o_ready,
  output logic [BW_DATA-1:0] o_q,
  output logic               o_valid,
`ifdef DFF_PIPE_SCLR_EN
  input  logic               i_sclr,
`endif
  input  logic               i_ready
);

  logic [DEPTH-1:0]              v, rdy, st_ld, st_v, src_v;
  logic [DEPTH-1:0][BW_DATA-1:0] d, src_d;

  // Ready ripples from the output back to the input in one combinational pass.
  always_comb begin
    rdy          = '0;
    rdy[DEPTH-1] = ~v[DEPTH-1] | i_ready;
    for (int k = DEPTH-2; k >= 0; k--)
      rdy[k] = ~v[k] | rdy[k+1];
  end

  assign src_v[0] = i_valid;
  assign src_d[0] = i_d;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k > 0) begin : g_src
      assign src_v[k] = v[k-1];
      assign src_d[k] = d[k-1];
    end

`ifdef DFF_PIPE_SCLR_EN
    // Flush forces every stage to load an empty slot; data flops stay untouched.
    assign st_ld[k] = rdy[k] | i_sclr;
    assign st_v[k]  = src_v[k] & ~i_sclr;
`else
    assign st_ld[k] = rdy[k];
    assign st_v[k]  = src_v[k];
`endif

    dff_pipe_stage #(
      .BW_DATA (BW_DATA),
      .RST_VAL (RST_VAL)
    ) u_stage (
      .i_clk   (i_clk),
      .i_rstn  (i_rstn),
      .i_d     (src_d[k]),
      .i_valid (st_v[k]),
      .i_ld    (st_ld[k]),
      .o_q     (d[k]),
      .o_valid (v[k])
    );
  end

  assign o_ready = rdy[0];
  assign o_q     = d[DEPTH-1];
  assign o_valid = v[DEPTH-1];

endmodule
